// File: rtl/score_disp_pkg.sv
// Shared glyph constants and FSM state type for the score display driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package score_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b100_0000;
    localparam logic [6:0] SEG_1     = 7'b111_1001;
    localparam logic [6:0] SEG_2     = 7'b010_0100;
    localparam logic [6:0] SEG_3     = 7'b011_0000;
    localparam logic [6:0] SEG_4     = 7'b001_1001;
    localparam logic [6:0] SEG_5     = 7'b001_0010;
    localparam logic [6:0] SEG_6     = 7'b000_0010;
    localparam logic [6:0] SEG_7     = 7'b111_1000;
    localparam logic [6:0] SEG_8     = 7'b000_0000;
    localparam logic [6:0] SEG_9     = 7'b001_0000;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;
    localparam logic [6:0] SEG_ERR   = 7'b011_0110;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StUpdate
    } state_e;

endpackage

// File: rtl/seg7_digit_dec.sv
// Combinational BCD nibble to active-low 7-segment glyph; non-decimal nibbles
// map to the error glyph.
module seg7_digit_dec
    import score_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_ERR;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/score_bin2seg_nd.sv
// Binary score to multi-digit 7-segment driver: iterative double-dabble, one
// shift per clock, with overflow detection and optional leading-zero blanking.
module score_bin2seg_nd
    import score_disp_pkg::*;
#(
    parameter int unsigned BIN_W      = 14,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [BIN_W-1:0]        bin_in,
    input  logic                    blank_en,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int unsigned SCR_W = 4 * NUM_DIGITS;
    localparam int unsigned HEX_W = 7 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   sr_q, sr_d;
    logic [SCR_W-1:0]   scr_q, scr_d, scr_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               blank_q, blank_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic [HEX_W-1:0]   hex_q, hex_d;
    logic [HEX_W-1:0]   glyph;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic               zero_above;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_digit_dec u_dec (
            .digit (scr_q[4*g +: 4]),
            .seg   (glyph[7*g +: 7])
        );
    end

    // Per-digit add-3 with no carry between digits.
    always_comb begin
        scr_adj = scr_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5) begin
                scr_adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // A digit is blanked when it and every digit above it are zero; units never.
    always_comb begin
        zero_above = 1'b1;
        blank_mask = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            zero_above    = zero_above && (scr_q[4*k +: 4] == 4'd0);
            blank_mask[k] = blank_q && zero_above && (k != 0);
        end
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        blank_d    = blank_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        bcd_d      = bcd_q;
        hex_d      = hex_q;
        case (state_q)
            StIdle: begin
                if (load) begin
                    sr_d    = bin_in;
                    scr_d   = '0;
                    ovf_d   = 1'b0;
                    blank_d = blank_en;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = StShift;
                end
            end
            StShift: begin
                scr_d = {scr_adj[SCR_W-2:0], sr_q[BIN_W-1]};
                sr_d  = sr_q << 1;
                if (scr_adj[SCR_W-1]) begin
                    ovf_d = 1'b1;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                bcd_d      = scr_q;
                overflow_d = ovf_q;
                done_d     = 1'b1;
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (ovf_q) begin
                        hex_d[7*k +: 7] = SEG_ERR;
                    end else if (blank_mask[k]) begin
                        hex_d[7*k +: 7] = SEG_BLANK;
                    end else begin
                        hex_d[7*k +: 7] = glyph[7*k +: 7];
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            sr_q       <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            blank_q    <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= '0;
            hex_q      <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            blank_q    <= blank_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            bcd_q      <= bcd_d;
            hex_q      <= hex_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign overflow = overflow_q;
    assign bcd_out  = bcd_q;
    assign hex_out  = hex_q;

endmodule

// File: tb/tb_score_bin2seg_nd.sv
// Directed bench for score_bin2seg_nd with hand-computed BCD and glyph vectors.
module tb_score_bin2seg_nd;

    localparam int BIN_W = 14;
    localparam int ND    = 4;

    localparam logic [6:0] G0 = 7'b100_0000;
    localparam logic [6:0] G1 = 7'b111_1001;
    localparam logic [6:0] G2 = 7'b010_0100;
    localparam logic [6:0] G3 = 7'b011_0000;
    localparam logic [6:0] G4 = 7'b001_1001;
    localparam logic [6:0] G5 = 7'b001_0010;
    localparam logic [6:0] G7 = 7'b111_1000;
    localparam logic [6:0] G9 = 7'b001_0000;
    localparam logic [6:0] GB = 7'b111_1111;
    localparam logic [6:0] GE = 7'b011_0110;

    logic              clk = 1'b0;
    logic              rst;
    logic              load;
    logic [BIN_W-1:0]  bin_in;
    logic              blank_en;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [4*ND-1:0]   bcd_out;
    logic [7*ND-1:0]   hex_out;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;

    score_bin2seg_nd #(
        .BIN_W      (BIN_W),
        .NUM_DIGITS (ND)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .bin_in   (bin_in),
        .blank_en (blank_en),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bcd_out  (bcd_out),
        .hex_out  (hex_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Leaves the bench in cycle 0 (just after the accepting edge).
    task automatic start(input logic [BIN_W-1:0] val, input logic blank);
        load     = 1'b1;
        bin_in   = val;
        blank_en = blank;
        tick();
        load     = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic convert(input string tag, input logic [BIN_W-1:0] val, input logic blank,
                           input logic [15:0] exp_bcd, input logic [27:0] exp_hex,
                           input logic exp_ovf);
        int c;
        start(val, blank);
        wait_done(c);
        check({tag, "_latency"}, 64'(c), 64'd15);
        check({tag, "_bcd"}, 64'(bcd_out), 64'(exp_bcd));
        check({tag, "_hex"}, 64'(hex_out), 64'(exp_hex));
        check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        bin_in   = '0;
        blank_en = 1'b0;
        tick();
        check("rst_hex", 64'(hex_out), 64'({GB, GB, GB, GB}));
        check("rst_bcd", 64'(bcd_out), 64'd0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);
        check("idle_ovf", 64'(overflow), 64'd0);
        check("idle_hex", 64'(hex_out), 64'({GB, GB, GB, GB}));

        convert("c1234", 14'd1234, 1'b0, 16'h1234, {G1, G2, G3, G4}, 1'b0);
        check("c1234_busy_at_done", 64'(busy), 64'd0);
        tick();
        check("c1234_done_pulse", 64'(done), 64'd0);
        check("c1234_hold", 64'(bcd_out), 64'h1234);

        convert("c7_blank", 14'd7, 1'b1, 16'h0007, {GB, GB, GB, G7}, 1'b0);
        convert("c0_blank", 14'd0, 1'b1, 16'h0000, {GB, GB, GB, G0}, 1'b0);
        convert("c30_blank", 14'd30, 1'b1, 16'h0030, {GB, GB, G3, G0}, 1'b0);
        convert("c1005_blank", 14'd1005, 1'b1, 16'h1005, {G1, G0, G0, G5}, 1'b0);
        convert("c7_noblank", 14'd7, 1'b0, 16'h0007, {G0, G0, G0, G7}, 1'b0);
        convert("c10000", 14'd10000, 1'b0, 16'h0000, {GE, GE, GE, GE}, 1'b1);
        convert("c16383", 14'd16383, 1'b1, 16'h6383, {GE, GE, GE, GE}, 1'b1);
        convert("c9999", 14'd9999, 1'b1, 16'h9999, {G9, G9, G9, G9}, 1'b0);

        // load 42, then spurious loads of 55 during SHIFT and UPDATE
        start(14'd42, 1'b0);
        bin_in = 14'd55;
        repeat (3) tick();
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (10) tick();
        check("ign_update_busy", 64'(busy), 64'd1);
        load = 1'b1;
        tick();
        check("ign_done", 64'(done), 64'd1);
        check("ign_bcd", 64'(bcd_out), 64'h0042);
        check("ign_hex", 64'(hex_out), 64'({G0, G0, G4, G2}));
        tick();
        load = 1'b0;
        check("after_done_accept", 64'(busy), 64'd1);
        wait_done(cyc);
        check("after_done_latency", 64'(cyc), 64'd15);
        check("after_done_bcd", 64'(bcd_out), 64'h0055);

        // asynchronous reset in SHIFT cycle 6
        start(14'd1234, 1'b0);
        repeat (6) tick();
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #2;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_bcd", 64'(bcd_out), 64'd0);
        check("arst_hex", 64'(hex_out), 64'({GB, GB, GB, GB}));
        check("arst_ovf", 64'(overflow), 64'd0);
        tick();
        rst = 1'b0;
        wait_done(cyc);
        check("arst_no_done", 64'(cyc), 64'd40);
        convert("post_rst", 14'd321, 1'b0, 16'h0321, {G0, G3, G2, G1}, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
